// File: rtl/tdc_interval_packer.sv
// Start/stop interval calculator for the TDC core: pairs start and stop time stamps,
// converts them to an interval in fine bins, tags it with status flags and queues it for readout.
module tdc_interval_packer #(
    parameter int COARSE_W   = 16,
    parameter int FINE_W     = 8,
    parameter int FINE_BINS  = 128,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 65535
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ev_valid,
    input  logic                        ev_is_stop,
    input  logic [COARSE_W-1:0]         coarse_in,
    input  logic [FINE_W-1:0]           fine_in,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [31:0]                 m_data,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [7:0]                  drop_cnt,
    output logic [7:0]                  orphan_cnt
);

    localparam int IW = 29;
    localparam int SW = IW + 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [FINE_W-1:0] FINE_MAX   = FINE_W'(FINE_BINS - 1);
    localparam logic [TW-1:0]     TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [LW-1:0]     LEVEL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_CALC  = 2'd2,
        S_PUSH  = 2'd3
    } state_t;

    state_t              state_q;
    logic [COARSE_W-1:0] c_start_q;
    logic [COARSE_W-1:0] c_stop_q;
    logic [FINE_W-1:0]   f_start_q;
    logic [FINE_W-1:0]   f_stop_q;
    logic                clamp_start_q;
    logic                clamp_stop_q;
    logic                restart_q;
    logic                timeout_q;
    logic [TW-1:0]       timer_q;
    logic [31:0]         res_q;

    logic [31:0]         mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q;
    logic [AW-1:0]       rd_ptr_q;
    logic [LW-1:0]       level_q;
    logic [7:0]          drop_q;
    logic [7:0]          orphan_q;

    logic                ev_start;
    logic                ev_stop;
    logic                fine_over;
    logic [FINE_W-1:0]   fine_sat;
    logic [COARSE_W-1:0] coarse_diff;
    logic [SW-1:0]       span;
    logic [SW-1:0]       stop_bins;
    logic                interval_neg;
    logic [IW-1:0]       interval;
    logic                push_req;
    logic                fifo_full;
    logic                push_ok;
    logic                pop;
    logic                orphan_hit;

    assign ev_start  = ev_valid & ~ev_is_stop;
    assign ev_stop   = ev_valid & ev_is_stop;
    assign fine_over = fine_in > FINE_MAX;
    assign fine_sat  = fine_over ? FINE_MAX : fine_in;

    // Coarse difference wraps modulo 2^COARSE_W, so a single counter rollover is absorbed here.
    assign coarse_diff  = c_stop_q - c_start_q;
    assign span         = SW'(coarse_diff) * SW'(FINE_BINS) + SW'(f_start_q);
    assign stop_bins    = SW'(f_stop_q);
    assign interval_neg = span < stop_bins;
    assign interval     = interval_neg ? '0 : IW'(span - stop_bins);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            c_start_q     <= '0;
            c_stop_q      <= '0;
            f_start_q     <= '0;
            f_stop_q      <= '0;
            clamp_start_q <= 1'b0;
            clamp_stop_q  <= 1'b0;
            restart_q     <= 1'b0;
            timeout_q     <= 1'b0;
            timer_q       <= '0;
            res_q         <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ev_start) begin
                        c_start_q     <= coarse_in;
                        f_start_q     <= fine_sat;
                        clamp_start_q <= fine_over;
                        timer_q       <= '0;
                        state_q       <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    timer_q <= timer_q + 1'b1;
                    // Any event outranks the timeout that would fire on the same edge.
                    if (ev_stop) begin
                        c_stop_q     <= coarse_in;
                        f_stop_q     <= fine_sat;
                        clamp_stop_q <= fine_over;
                        state_q      <= S_CALC;
                    end else if (ev_start) begin
                        c_start_q     <= coarse_in;
                        f_start_q     <= fine_sat;
                        clamp_start_q <= fine_over;
                        timer_q       <= '0;
                        restart_q     <= 1'b1;
                    end else if (timer_q == TIMER_LAST) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (timeout_q) begin
                        res_q <= {1'b1, clamp_start_q, restart_q, {IW{1'b0}}};
                    end else begin
                        res_q <= {1'b0, clamp_start_q | clamp_stop_q | interval_neg,
                                  restart_q, interval};
                    end
                    state_q <= S_PUSH;
                end
                default: begin
                    clamp_start_q <= 1'b0;
                    clamp_stop_q  <= 1'b0;
                    restart_q     <= 1'b0;
                    timeout_q     <= 1'b0;
                    state_q       <= S_IDLE;
                end
            endcase
        end
    end

    assign orphan_hit = ev_stop && (state_q != S_ARMED);

    always_ff @(posedge clk) begin
        if (rst) begin
            orphan_q <= '0;
        end else if (orphan_hit && (orphan_q != 8'hFF)) begin
            orphan_q <= orphan_q + 8'd1;
        end
    end

    // Fullness is judged before any same-edge pop, so a simultaneous pop never saves a push.
    assign push_req  = (state_q == S_PUSH);
    assign fifo_full = (level_q == LEVEL_FULL);
    assign push_ok   = push_req & ~fifo_full;
    assign m_valid   = (level_q != '0);
    assign pop       = m_valid & m_ready;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= res_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            if (push_req && fifo_full && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    assign m_data     = m_valid ? mem[rd_ptr_q] : 32'd0;
    assign fifo_level = level_q;
    assign drop_cnt   = drop_q;
    assign orphan_cnt = orphan_q;

endmodule

// File: tb/tb_tdc_interval_packer.sv
// Bench for tdc_interval_packer: directed scenarios plus randomized start/stop pairs,
// all compared against an arithmetic model of the interval and a queue model of the FIFO.
module tb_tdc_interval_packer;

    localparam int FINE_BINS  = 128;
    localparam int DEPTH      = 16;
    localparam int TIMEOUT_TB = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        ev_valid;
    logic        ev_is_stop;
    logic [15:0] coarse_in;
    logic [7:0]  fine_in;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [4:0]  fifo_level;
    logic [7:0]  drop_cnt;
    logic [7:0]  orphan_cnt;

    int checks = 0;
    int errors = 0;
    int exp_orphan = 0;
    int exp_drop = 0;
    logic [31:0] model_q[$];

    tdc_interval_packer #(
        .COARSE_W  (16),
        .FINE_W    (8),
        .FINE_BINS (FINE_BINS),
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT   (TIMEOUT_TB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ev_valid  (ev_valid),
        .ev_is_stop(ev_is_stop),
        .coarse_in (coarse_in),
        .fine_in   (fine_in),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .fifo_level(fifo_level),
        .drop_cnt  (drop_cnt),
        .orphan_cnt(orphan_cnt)
    );

    always #5 clk = ~clk;

    // Interval from the event-time definition T = C*FINE_BINS - F with 16-bit coarse wrap.
    function automatic logic [31:0] expect_rec(input int cs, input int fs, input int cp,
                                               input int fp, input bit restart);
        int fsc;
        int fpc;
        int diff;
        int iv;
        bit clamp;
        logic [31:0] rec;
        clamp = 1'b0;
        fsc = fs;
        fpc = fp;
        if (fsc > FINE_BINS - 1) begin fsc = FINE_BINS - 1; clamp = 1'b1; end
        if (fpc > FINE_BINS - 1) begin fpc = FINE_BINS - 1; clamp = 1'b1; end
        diff = (cp - cs) & 65535;
        iv = diff * FINE_BINS + fsc - fpc;
        if (iv < 0) begin iv = 0; clamp = 1'b1; end
        rec = 32'(iv);
        rec[31] = 1'b0;
        rec[30] = clamp;
        rec[29] = restart;
        return rec;
    endfunction

    function automatic int rand_fine();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(128, 255));
        return int'($urandom_range(0, 127));
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_event(input bit is_stop, input int c, input int f);
        @(negedge clk);
        ev_valid   = 1'b1;
        ev_is_stop = is_stop;
        coarse_in  = 16'(c);
        fine_in    = 8'(f);
        @(negedge clk);
        ev_valid   = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst      = 1'b1;
        ev_valid = 1'b0;
        m_ready  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_orphan = 0;
        exp_drop   = 0;
        model_q.delete();
    endtask

    // Start/stop pair, then wait until the record has been written; the model FIFO follows.
    task automatic run_pair(input int cs, input int fs, input int cp, input int fp);
        drive_event(1'b0, cs, fs);
        drive_event(1'b1, cp, fp);
        wait_cycles(2);
        if (model_q.size() >= DEPTH) exp_drop++;
        else model_q.push_back(expect_rec(cs, fs, cp, fp, 1'b0));
    endtask

    task automatic pop_one(output logic [31:0] data, output bit ok);
        ok = 1'b0;
        data = '0;
        for (int i = 0; i < 20; i++) begin
            if (m_valid === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (ok) begin
            data = m_data;
            m_ready = 1'b1;
            @(negedge clk);
            m_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ev_valid = 1'b0; ev_is_stop = 1'b0; m_ready = 1'b0;
        coarse_in = '0; fine_in = '0;
        wait_cycles(3);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %0b expected 0", m_valid); end
        checks++; if (m_data !== 32'd0) begin errors++; $display("FAIL reset_m_data: got %h expected 0", m_data); end
        checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
        checks++; if (orphan_cnt !== 8'd0) begin errors++; $display("FAIL reset_orphan: got %0d expected 0", orphan_cnt); end
        $display("reset: checked idle outputs");
    endtask

    task automatic test_basic();
        logic [31:0] exp;
        exp = expect_rec(10, 5, 13, 20, 1'b0);
        drive_event(1'b0, 10, 5);
        drive_event(1'b1, 13, 20);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_n0: got %0b expected 0", m_valid); end
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_n1: got %0b expected 0", m_valid); end
        @(negedge clk);
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_n2: got %0b expected 1", m_valid); end
        checks++; if (m_data !== exp) begin errors++; $display("FAIL basic_data: got %h expected %h", m_data, exp); end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_drained: got %0b expected 0", m_valid); end
        $display("basic: start 10/5 stop 13/20 data %h", exp);
    endtask

    task automatic test_wrap_and_clamp();
        logic [31:0] got;
        logic [31:0] exp;
        bit ok;
        int cs [3] = '{65534, 7, 3};
        int fs [3] = '{0, 40, 10};
        int cp [3] = '{1, 7, 5};
        int fp [3] = '{0, 50, 200};
        for (int i = 0; i < 3; i++) begin
            run_pair(cs[i], fs[i], cp[i], fp[i]);
            pop_one(got, ok);
            exp = model_q.pop_front();
            checks++;
            if (!ok || got !== exp) begin
                errors++;
                $display("FAIL wrap_clamp_%0d: got %h (valid seen %0b) expected %h", i, got, ok, exp);
            end
            $display("wrap/clamp %0d: start %0d/%0d stop %0d/%0d data %h", i, cs[i], fs[i], cp[i], fp[i], exp);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] got;
        logic [31:0] exp;
        bit ok;
        drive_event(1'b0, 100, 3);
        wait_cycles(TIMEOUT_TB + 1);
        checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL timeout_early: got level %0d expected 0", fifo_level); end
        @(negedge clk);
        checks++; if (fifo_level !== 5'd1) begin errors++; $display("FAIL timeout_level: got %0d expected 1", fifo_level); end
        pop_one(got, ok);
        checks++; if (!ok || got !== 32'h8000_0000) begin errors++; $display("FAIL timeout_data: got %h expected 80000000", got); end
        drive_event(1'b1, 4, 4);
        exp_orphan++;
        checks++; if (orphan_cnt !== 8'(exp_orphan)) begin errors++; $display("FAIL timeout_orphan: got %0d expected %0d", orphan_cnt, exp_orphan); end
        $display("timeout: record %h then orphan stop", got);

        // Stop on the very edge the timeout would fire: the stop must win.
        drive_event(1'b0, 20, 10);
        wait_cycles(TIMEOUT_TB - 2);
        drive_event(1'b1, 21, 0);
        wait_cycles(2);
        exp = expect_rec(20, 10, 21, 0, 1'b0);
        pop_one(got, ok);
        checks++; if (!ok || got !== exp) begin errors++; $display("FAIL timeout_priority: got %h expected %h", got, exp); end
        $display("timeout priority: data %h", got);

        // One edge later the timeout has fired and the stop lands in CALC as an orphan.
        drive_event(1'b0, 20, 10);
        wait_cycles(TIMEOUT_TB - 1);
        drive_event(1'b1, 21, 0);
        exp_orphan++;
        wait_cycles(2);
        pop_one(got, ok);
        checks++; if (!ok || got !== 32'h8000_0000) begin errors++; $display("FAIL timeout_late_stop: got %h expected 80000000", got); end
        checks++; if (orphan_cnt !== 8'(exp_orphan)) begin errors++; $display("FAIL timeout_late_orphan: got %0d expected %0d", orphan_cnt, exp_orphan); end
        $display("timeout late stop: data %h orphans %0d", got, orphan_cnt);
    endtask

    task automatic test_fifo_full();
        logic [31:0] exp;
        apply_reset();
        for (int i = 0; i < DEPTH + 1; i++) begin
            int cs;
            cs = int'($urandom_range(0, 65535));
            run_pair(cs, int'($urandom_range(0, 127)), cs + int'($urandom_range(0, 50)),
                     int'($urandom_range(0, 127)));
        end
        checks++; if (fifo_level !== 5'(model_q.size())) begin errors++; $display("FAIL full_level: got %0d expected %0d", fifo_level, model_q.size()); end
        checks++; if (drop_cnt !== 8'(exp_drop)) begin errors++; $display("FAIL full_drop: got %0d expected %0d", drop_cnt, exp_drop); end
        wait_cycles(3);
        checks++; if (m_data !== model_q[0]) begin errors++; $display("FAIL full_head_stable: got %h expected %h", m_data, model_q[0]); end
        $display("fifo full: level %0d drops %0d", fifo_level, drop_cnt);
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            exp = model_q.pop_front();
            checks++;
            if (m_valid !== 1'b1 || m_data !== exp) begin
                errors++;
                $display("FAIL drain_%0d: got valid %0b data %h expected valid 1 data %h", i, m_valid, m_data, exp);
            end
            $display("drain %0d: data %h", i, exp);
            @(negedge clk);
        end
        m_ready = 1'b0;
        checks++; if (m_valid !== 1'b0 || fifo_level !== 5'd0) begin errors++; $display("FAIL drain_empty: got valid %0b level %0d expected 0 0", m_valid, fifo_level); end
    endtask

    task automatic test_reset_mid_and_restart();
        logic [31:0] got;
        logic [31:0] exp;
        bit ok;
        apply_reset();
        drive_event(1'b0, 5, 0);
        apply_reset();
        drive_event(1'b1, 9, 0);
        exp_orphan++;
        wait_cycles(3);
        checks++; if (fifo_level !== 5'd0 || m_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_empty: got level %0d valid %0b expected 0 0", fifo_level, m_valid); end
        checks++; if (orphan_cnt !== 8'(exp_orphan)) begin errors++; $display("FAIL reset_mid_orphan: got %0d expected %0d", orphan_cnt, exp_orphan); end
        $display("reset mid-measurement: orphans %0d", orphan_cnt);

        drive_event(1'b0, 1, 2);
        drive_event(1'b0, 3, 4);
        drive_event(1'b1, 5, 6);
        wait_cycles(2);
        exp = expect_rec(3, 4, 5, 6, 1'b1);
        pop_one(got, ok);
        checks++; if (!ok || got !== exp) begin errors++; $display("FAIL restart_data: got %h expected %h", got, exp); end
        checks++; if (got[29] !== 1'b1) begin errors++; $display("FAIL restart_flag: got %0b expected 1", got[29]); end
        $display("restart: data %h", got);
    endtask

    task automatic test_random();
        m_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            int cs;
            int fs;
            int cp;
            int fp;
            bit restart;
            logic [31:0] exp;
            if ($urandom_range(0, 4) == 0) begin
                drive_event(1'b1, int'($urandom_range(0, 65535)), rand_fine());
                exp_orphan++;
            end
            cs = int'($urandom_range(0, 65535));
            fs = rand_fine();
            drive_event(1'b0, cs, fs);
            restart = ($urandom_range(0, 3) == 0);
            if (restart) begin
                cs = int'($urandom_range(0, 65535));
                fs = rand_fine();
                drive_event(1'b0, cs, fs);
            end
            wait_cycles(int'($urandom_range(0, 4)));
            if ($urandom_range(0, 3) == 0) cp = int'($urandom_range(0, 65535));
            else cp = (cs + int'($urandom_range(0, 3))) & 65535;
            fp = rand_fine();
            drive_event(1'b1, cp, fp);
            wait_cycles(2);
            exp = expect_rec(cs, fs, cp, fp, restart);
            checks++;
            if (m_valid !== 1'b1 || m_data !== exp) begin
                errors++;
                $display("FAIL random_%0d: got valid %0b data %h expected valid 1 data %h", n, m_valid, m_data, exp);
            end
            $display("random %0d: start %0d/%0d stop %0d/%0d restart %0b data %h", n, cs, fs, cp, fp, restart, exp);
            @(negedge clk);
            checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL random_pop_%0d: got valid %0b expected 0", n, m_valid); end
        end
        m_ready = 1'b0;
        checks++; if (orphan_cnt !== 8'(exp_orphan)) begin errors++; $display("FAIL random_orphan: got %0d expected %0d", orphan_cnt, exp_orphan); end
        checks++; if (drop_cnt !== 8'(exp_drop)) begin errors++; $display("FAIL random_drop: got %0d expected %0d", drop_cnt, exp_drop); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap_and_clamp();
        test_timeout();
        test_fifo_full();
        test_reset_mid_and_restart();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
